// File: rtl/fir_pkg.sv
// Shared types and helpers for the polyphase interpolating FIR: FSM state,
// constant log2 and the arithmetic-shift-then-saturate width reduction.
package fir_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int f_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Operands arrive sign-extended to 64 bits so one helper serves every width.
    function automatic logic signed [63:0] f_sat_trunc(
        input logic signed [63:0] value,
        input int                 nbOut,
        input int                 dropBits
    );
        logic signed [63:0] shifted;
        logic signed [63:0] maxVal;
        logic signed [63:0] minVal;
        shifted = value >>> dropBits;
        maxVal  = (64'sd1 <<< (nbOut - 1)) - 64'sd1;
        minVal  = -(64'sd1 <<< (nbOut - 1));
        if (shifted > maxVal) begin
            return maxVal;
        end else if (shifted < minVal) begin
            return minVal;
        end
        return shifted;
    endfunction

endpackage

// File: rtl/fir_sat_round.sv
// Combinational accumulator-to-output width reduction: optional round half up
// (macro FIR_ROUND_EN), arithmetic shift, then saturation. Never wraps.
module fir_sat_round
    import fir_pkg::*;
#(
    parameter int NB_ACC    = 19,
    parameter int NB_OUTPUT = 8,
    parameter int DROP      = 7
) (
    input  logic signed [NB_ACC-1:0]    i_acc,
    output logic signed [NB_OUTPUT-1:0] o_data
);

    logic signed [63:0] w_wide;

`ifdef FIR_ROUND_EN
    localparam int                ROUND_POS   = (DROP > 0) ? DROP - 1 : 0;
    localparam logic [NB_ACC:0]   ROUND_CONST = (DROP > 0) ? ((NB_ACC + 1)'(1) << ROUND_POS) : '0;

    // One extra bit so the rounding add itself cannot overflow before saturation.
    logic signed [NB_ACC:0] w_rounded;
    assign w_rounded = $signed({i_acc[NB_ACC-1], i_acc}) + $signed(ROUND_CONST);
    assign w_wide    = {{(63 - NB_ACC){w_rounded[NB_ACC]}}, w_rounded};
`else
    assign w_wide    = {{(64 - NB_ACC){i_acc[NB_ACC-1]}}, i_acc};
`endif

    assign o_data = NB_OUTPUT'(f_sat_trunc(w_wide, NB_OUTPUT, DROP));

endmodule

// File: rtl/fir_polyphase_interp.sv
// Polyphase interpolating FIR (upsample by OS) with valid/ready on both sides.
// Build macro FIR_ROUND_EN selects round-half-up instead of truncation.
module fir_polyphase_interp
    import fir_pkg::*;
#(
    parameter int NB_INPUT   = 8,
    parameter int NBF_INPUT  = 7,
    parameter int NB_OUTPUT  = 8,
    parameter int NBF_OUTPUT = 7,
    parameter int NB_COEFF   = 8,
    parameter int NBF_COEFF  = 7,
    parameter int OS         = 4,
    parameter int N_TAPS     = 6,
    parameter logic [OS*N_TAPS*NB_COEFF-1:0] COEFFS = {
        8'h01, 8'h02, 8'h03, 8'h00, 8'hF9, 8'hF1, 8'hF0, 8'h00,
        8'h22, 8'h4D, 8'h72, 8'h80, 8'h72, 8'h4D, 8'h22, 8'h00,
        8'hF0, 8'hF1, 8'hF9, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00
    }
) (
    input  logic                        clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic signed [NB_INPUT-1:0]  i_data,
    input  logic                        i_valid,
    output logic                        o_in_ready,
    output logic signed [NB_OUTPUT-1:0] o_data,
    output logic                        o_valid,
    input  logic                        i_out_ready
);

    localparam int L        = OS * N_TAPS;
    localparam int NB_ACC   = NB_INPUT + NB_COEFF + f_clog2(N_TAPS);
    localparam int NB_PHASE = (f_clog2(OS) < 1) ? 1 : f_clog2(OS);
    localparam int IDX_W    = (f_clog2(L) < 1) ? 1 : f_clog2(L);
    localparam int DROP     = NBF_INPUT + NBF_COEFF - NBF_OUTPUT;

    localparam logic [NB_COEFF-1:0]    C_MOST_NEG = {1'b1, {(NB_COEFF - 1){1'b0}}};
    localparam logic signed [NB_COEFF:0] C_UNITY  = {2'b01, {(NB_COEFF - 1){1'b0}}};

    state_t                        r_state;
    logic [NB_PHASE-1:0]           r_phase;
    logic signed [NB_INPUT-1:0]    r_x [N_TAPS];
    logic signed [NB_OUTPUT-1:0]   r_data;
    logic                          r_valid;

    logic                          w_lastPhase;
    logic                          w_inReady;
    logic                          w_inAcc;
    logic                          w_outAcc;
    logic [NB_PHASE-1:0]           w_pSel;
    logic signed [NB_INPUT-1:0]    w_xSel [N_TAPS];
    logic signed [NB_COEFF:0]      w_coefTab [L];
    logic signed [NB_ACC-1:0]      w_acc;
    logic signed [NB_OUTPUT-1:0]   w_yOut;

    // The most negative code stands for +1.0 so a unity centre tap fits in
    // NB_COEFF bits; a -1.0 tap never occurs in a raised-cosine prototype.
    for (genvar k = 0; k < L; k++) begin : g_coef
        localparam logic [NB_COEFF-1:0] RAW = COEFFS[k*NB_COEFF +: NB_COEFF];
        assign w_coefTab[k] = (RAW == C_MOST_NEG) ? C_UNITY : $signed({RAW[NB_COEFF-1], RAW});
    end

    assign w_lastPhase = (r_phase == NB_PHASE'(OS - 1));
    assign w_inReady   = i_enable & ((r_state == IDLE) | ((r_state == RUN) & w_lastPhase & i_out_ready));
    assign w_inAcc     = i_valid & w_inReady;
    assign w_outAcc    = r_valid & i_out_ready & i_enable;
    assign w_pSel      = w_inAcc ? '0 : r_phase + NB_PHASE'(1);

    // The filter evaluates the sample set and phase that will be current next cycle.
    always_comb begin
        for (int t = 0; t < N_TAPS; t++) begin
            w_xSel[t] = r_x[t];
        end
        if (w_inAcc) begin
            w_xSel[0] = i_data;
            for (int t = 1; t < N_TAPS; t++) begin
                w_xSel[t] = r_x[t-1];
            end
        end
    end

    always_comb begin : p_mac
        logic [IDX_W-1:0]         idx;
        logic signed [NB_ACC-1:0] xExt;
        logic signed [NB_ACC-1:0] cExt;
        w_acc = '0;
        for (int t = 0; t < N_TAPS; t++) begin
            idx   = IDX_W'(t * OS) + IDX_W'(w_pSel);
            xExt  = {{(NB_ACC - NB_INPUT){w_xSel[t][NB_INPUT-1]}}, w_xSel[t]};
            cExt  = {{(NB_ACC - NB_COEFF - 1){w_coefTab[idx][NB_COEFF]}}, w_coefTab[idx]};
            w_acc = w_acc + xExt * cExt;
        end
    end

    fir_sat_round #(
        .NB_ACC    (NB_ACC),
        .NB_OUTPUT (NB_OUTPUT),
        .DROP      (DROP)
    ) u_sat_round (
        .i_acc  (w_acc),
        .o_data (w_yOut)
    );

    // A new sample wins over retiring the last phase, which keeps full rate.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            for (int t = 0; t < N_TAPS; t++) begin
                r_x[t] <= '0;
            end
        end else if (i_enable) begin
            if (w_inAcc) begin
                for (int t = 0; t < N_TAPS; t++) begin
                    r_x[t] <= w_xSel[t];
                end
                r_phase <= '0;
                r_state <= RUN;
                r_valid <= 1'b1;
                r_data  <= w_yOut;
            end else if (w_outAcc) begin
                if (!w_lastPhase) begin
                    r_phase <= w_pSel;
                    r_data  <= w_yOut;
                end else begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_in_ready = w_inReady;
    assign o_data     = r_data;
    assign o_valid    = r_valid;

endmodule

// File: tb/tb_fir_polyphase_interp.sv
// Directed bench for fir_polyphase_interp; expected values are hand-computed
// for both the truncating and the FIR_ROUND_EN build.
module tb_fir_polyphase_interp;

    typedef struct packed {
        logic [7:0]      din;
        logic [3:0][7:0] exp;
        logic            chk;
    } vec_t;

    logic              clock = 1'b0;
    logic              iReset;
    logic              iEnable;
    logic signed [7:0] iData;
    logic              iValid;
    logic              oInReady;
    logic signed [7:0] oData;
    logic              oValid;
    logic              iOutReady;

    int   total = 0;
    int   bad   = 0;
    vec_t vecs [18];

    fir_polyphase_interp dut (
        .clock       (clock),
        .i_reset     (iReset),
        .i_enable    (iEnable),
        .i_data      (iData),
        .i_valid     (iValid),
        .o_in_ready  (oInReady),
        .o_data      (oData),
        .o_valid     (oValid),
        .i_out_ready (iOutReady)
    );

    always #5 clock = ~clock;

    function automatic vec_t mkVec(input int din, input int e0, input int e1,
                                   input int e2, input int e3, input logic chk);
        vec_t v;
        v.din    = 8'(din);
        v.exp[0] = 8'(e0);
        v.exp[1] = 8'(e1);
        v.exp[2] = 8'(e2);
        v.exp[3] = 8'(e3);
        v.chk    = chk;
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
        end
    endtask

    // Presents one sample, waits (bounded) for acceptance, then walks phases 0..3.
    task automatic applyStimulus(input vec_t v, input string tag);
        int cnt;
        iData  = $signed(v.din);
        iValid = 1'b1;
        #1;
        cnt = 0;
        while (!oInReady && cnt < 20) begin
            tick();
            cnt++;
        end
        if (!oInReady) checkOutput({tag, "_acceptTimeout"}, 0, 1);
        tick();
        iValid = 1'b0;
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick();
            if (v.chk) begin
                checkOutput($sformatf("%s_p%0d_valid", tag, p), int'(oValid), 1);
                checkOutput($sformatf("%s_p%0d_data", tag, p), int'(oData), int'($signed(v.exp[p])));
            end
        end
    endtask

    task automatic flushToIdle(input string tag);
        int cnt;
        iValid = 1'b0;
        #1;
        cnt = 0;
        while (oValid && cnt < 10) begin
            tick();
            cnt++;
        end
        checkOutput({tag, "_idleValid"}, int'(oValid), 0);
    endtask

    initial begin
`ifdef FIR_ROUND_EN
        vecs[0] = mkVec(127, 0, 1, 2, 3, 1'b1);
        vecs[1] = mkVec(0, 0, -7, -15, -16, 1'b1);
        vecs[2] = mkVec(0, 0, 34, 76, 113, 1'b1);
        vecs[3] = mkVec(0, 127, 113, 76, 34, 1'b1);
        vecs[4] = mkVec(0, 0, -16, -15, -7, 1'b1);
        vecs[5] = mkVec(0, 0, 3, 2, 1, 1'b1);
`else
        vecs[0] = mkVec(127, 0, 0, 1, 2, 1'b1);
        vecs[1] = mkVec(0, 0, -7, -15, -16, 1'b1);
        vecs[2] = mkVec(0, 0, 33, 76, 113, 1'b1);
        vecs[3] = mkVec(0, 127, 113, 76, 33, 1'b1);
        vecs[4] = mkVec(0, 0, -16, -15, -7, 1'b1);
        vecs[5] = mkVec(0, 0, 2, 1, 0, 1'b1);
`endif
        for (int i = 6; i < 12; i++) vecs[i] = mkVec(-128, -128, -128, -128, -128, i == 11);
        for (int i = 12; i < 18; i++) vecs[i] = mkVec(127, 127, 127, 127, 127, i == 17);

        iReset    = 1'b1;
        iEnable   = 1'b1;
        iData     = '0;
        iValid    = 1'b0;
        iOutReady = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
        #1;
        checkOutput("reset_valid", int'(oValid), 0);
        checkOutput("reset_data", int'(oData), 0);
        checkOutput("reset_inReady", int'(oInReady), 1);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end
        flushToIdle("table");
        checkOutput("table_idleInReady", int'(oInReady), 1);

        // Backpressure: x = {0,127,127,127,127,127} gives 127,127,125,125.
        iData  = 8'sd0;
        iValid = 1'b1;
        #1;
        tick();
        iValid = 1'b0;
        checkOutput("bp_p0", int'(oData), 127);
        tick();
        checkOutput("bp_p1", int'(oData), 127);
        tick();
        checkOutput("bp_p2", int'(oData), 125);
        iOutReady = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp_stall%0d_data", c), int'(oData), 125);
            checkOutput($sformatf("bp_stall%0d_valid", c), int'(oValid), 1);
            checkOutput($sformatf("bp_stall%0d_inReady", c), int'(oInReady), 0);
            tick();
        end
        checkOutput("bp_p2_held", int'(oData), 125);
        iOutReady = 1'b1;
        tick();
        checkOutput("bp_p3", int'(oData), 125);
        checkOutput("bp_p3_valid", int'(oValid), 1);
        iOutReady = 1'b0;
        iData     = 8'sd0;
        iValid    = 1'b1;
        #1;
        checkOutput("bp_p3_stall_inReady", int'(oInReady), 0);
        tick();
        checkOutput("bp_p3_stall_data", int'(oData), 125);
        iOutReady = 1'b1;
        #1;
        checkOutput("bp_p3_release_inReady", int'(oInReady), 1);
        tick();
        iValid = 1'b0;
        checkOutput("bp_next_p0", int'(oData), 127);
        flushToIdle("bp");

        // Continuous streaming: ready pulses only on phase 3.
        iData  = 8'sd64;
        iValid = 1'b1;
        #1;
        tick();
        for (int c = 0; c < 16; c++) begin
            checkOutput($sformatf("stream%0d_valid", c), int'(oValid), 1);
            checkOutput($sformatf("stream%0d_inReady", c), int'(oInReady), int'((c % 4) == 3));
            tick();
        end
        flushToIdle("stream");

        // Reset during phase 1 aborts the burst; impulse afterwards is clean.
        iData  = 8'sd127;
        iValid = 1'b1;
        #1;
        tick();
        iValid = 1'b0;
        tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        #1;
        checkOutput("midReset_valid", int'(oValid), 0);
        checkOutput("midReset_data", int'(oData), 0);
        checkOutput("midReset_inReady", int'(oInReady), 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("replay%0d", i));
        end
        flushToIdle("replay");

        iEnable = 1'b0;
        iValid  = 1'b1;
        #1;
        checkOutput("disabled_inReady", int'(oInReady), 0);
        tick();
        checkOutput("disabled_valid", int'(oValid), 0);
        iValid  = 1'b0;
        iEnable = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
